updown_counter: RTL and testbench



---
 rtl/updown_counter_pkg.sv | 20 ++
 rtl/updown_counter_prescaler.sv | 28 ++
 rtl/updown_counter.sv | 122 ++++++++++++
 tb/tb_updown_counter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/updown_counter_pkg.sv
// Shared types for the up/down counter slice.
// Direction and counting-mode encodings used by the top and the bench.
package updown_counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    typedef struct packed {
        logic adv;
        logic clip;
    } adv_info_t;

endpackage

// File: rtl/updown_counter_prescaler.sv
// Enable-tick divider: asserts tick on every PRESCALE-th enabled cycle.
// Built into updown_counter only when UPDOWN_COUNTER_PRESCALE_EN is defined.
module count_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic enable,
    output logic tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt;

    assign tick = enable && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tick ? '0 : cnt + PW'(1);
        end
    end

endmodule

// File: rtl/updown_counter.sv
// Up/down counter with wrap or saturate modes, load/clear and wrap flags.
// Optional enable prescaler: define UPDOWN_COUNTER_PRESCALE_EN.
module updown_counter
    import updown_counter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_COUNT = 2**WIDTH - 1,
    parameter int PRESCALE  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             enable,
    input  dir_e             dir,
    input  cnt_mode_e        mode,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] count,
    output logic             wrap_pulse,
    output logic             overflow_sticky,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH:0]   MAX_E = (WIDTH+1)'(MAX_COUNT);
    localparam logic [WIDTH:0]   MOD_E = MAX_E + 1'b1;

    if (WIDTH < 2 || MAX_COUNT < 1 || PRESCALE < 1) begin : g_bad_param
    end

    logic             adv;
    logic [WIDTH:0]   cnt_e;
    logic [WIDTH:0]   step_e;
    logic [WIDTH:0]   sum_e;
    logic [WIDTH-1:0] nxt;
    logic             clip;
    logic [WIDTH-1:0] load_c;

`ifdef UPDOWN_COUNTER_PRESCALE_EN
    logic tick;

    count_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (clear | load),
        .enable  (enable),
        .tick    (tick)
    );

    assign adv = enable & tick;
`else
    assign adv = enable;
`endif

    assign load_c = ({1'b0, load_val} > MAX_E) ? MAX_W : load_val;

    // All arithmetic is one bit wider so sums and borrows never alias.
    always_comb begin
        cnt_e  = {1'b0, count};
        step_e = {1'b0, step};
        if (step_e > MAX_E) begin
            step_e = MAX_E;
        end
        sum_e = cnt_e + step_e;
        nxt   = count;
        clip  = 1'b0;
        if (dir == DIR_UP) begin
            if (sum_e > MAX_E) begin
                clip = 1'b1;
                if (mode == CNT_SAT) begin
                    nxt = MAX_W;
                end else begin
                    nxt = WIDTH'(sum_e - MOD_E);
                end
            end else begin
                nxt = WIDTH'(sum_e);
            end
        end else begin
            if (step_e > cnt_e) begin
                clip = 1'b1;
                if (mode == CNT_SAT) begin
                    nxt = '0;
                end else begin
                    nxt = WIDTH'(cnt_e + MOD_E - step_e);
                end
            end else begin
                nxt = WIDTH'(cnt_e - step_e);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count           <= '0;
            wrap_pulse      <= 1'b0;
            overflow_sticky <= 1'b0;
        end else if (clear) begin
            count           <= '0;
            wrap_pulse      <= 1'b0;
            overflow_sticky <= 1'b0;
        end else if (load) begin
            count      <= load_c;
            wrap_pulse <= 1'b0;
        end else if (adv) begin
            count      <= nxt;
            wrap_pulse <= clip;
            if (clip) begin
                overflow_sticky <= 1'b1;
            end
        end else begin
            wrap_pulse <= 1'b0;
        end
    end

    assign at_max = (count == MAX_W);
    assign at_min = (count == '0);

endmodule

// File: tb/tb_updown_counter.sv
// Directed self-checking bench for updown_counter (WIDTH=4, MAX_COUNT=9).
// Prescaler vectors run when UPDOWN_COUNTER_PRESCALE_EN is defined.
module tb_updown_counter;
    import updown_counter_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clear;
    logic         load;
    logic [W-1:0] load_val;
    logic         enable;
    dir_e         dir;
    cnt_mode_e    mode;
    logic [W-1:0] step;
    logic [W-1:0] count;
    logic         wrap_pulse;
    logic         overflow_sticky;
    logic         at_max;
    logic         at_min;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    updown_counter #(
        .WIDTH     (W),
        .MAX_COUNT (9),
        .PRESCALE  (3)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .clear           (clear),
        .load            (load),
        .load_val        (load_val),
        .enable          (enable),
        .dir             (dir),
        .mode            (mode),
        .step            (step),
        .count           (count),
        .wrap_pulse      (wrap_pulse),
        .overflow_sticky (overflow_sticky),
        .at_max          (at_max),
        .at_min          (at_min)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic adv_chk(input string tag, input int c, input int wp);
        cyc();
        check({tag, " count"}, 32'(count), 32'(c));
        check({tag, " wrap"}, 32'(wrap_pulse), 32'(wp));
    endtask

    initial begin
        rst_n    = 1'b0;
        clear    = 1'b1;
        load     = 1'b1;
        load_val = 4'd5;
        enable   = 1'b1;
        dir      = DIR_UP;
        mode     = CNT_WRAP;
        step     = 4'd3;
        #2;
        cyc();
        check("rst count", 32'(count), 0);
        check("rst wrap", 32'(wrap_pulse), 0);
        check("rst sticky", 32'(overflow_sticky), 0);
        check("rst at_min", 32'(at_min), 1);
        check("rst at_max", 32'(at_max), 0);
        rst_n = 1'b1;
        clear = 1'b0;
        load  = 1'b0;

`ifdef UPDOWN_COUNTER_PRESCALE_EN
        step = 4'd1;
        for (int k = 1; k <= 9; k++) begin
            cyc();
            if (k % 3 == 0) begin
                check("ps count", 32'(count), 32'(k / 3));
            end else if (k == 1) begin
                check("ps hold", 32'(count), 0);
            end
        end
        cyc();
        check("ps pre-load", 32'(count), 3);
        load     = 1'b1;
        load_val = 4'd0;
        cyc();
        check("ps load", 32'(count), 0);
        load = 1'b0;
        cyc();
        cyc();
        check("ps restart hold", 32'(count), 0);
        cyc();
        check("ps restart tick", 32'(count), 1);
`else
        adv_chk("up1", 3, 0);
        adv_chk("up2", 6, 0);
        adv_chk("up3", 9, 0);
        check("up3 at_max", 32'(at_max), 1);
        adv_chk("up4", 2, 1);
        check("up4 sticky", 32'(overflow_sticky), 1);
        enable = 1'b0;
        adv_chk("idle", 2, 0);
        check("idle sticky", 32'(overflow_sticky), 1);

        enable   = 1'b1;
        load     = 1'b1;
        load_val = 4'd6;
        adv_chk("ld6", 6, 0);
        load = 1'b0;
        dir  = DIR_DOWN;
        mode = CNT_SAT;
        step = 4'd4;
        adv_chk("dsat1", 2, 0);
        adv_chk("dsat2", 0, 1);
        adv_chk("dsat3", 0, 1);
        check("dsat at_min", 32'(at_min), 1);

        load     = 1'b1;
        load_val = 4'd15;
        adv_chk("ld15", 9, 0);
        check("ld15 at_max", 32'(at_max), 1);
        clear = 1'b1;
        adv_chk("clr+ld", 0, 0);
        check("clr sticky", 32'(overflow_sticky), 0);
        clear = 1'b0;
        load  = 1'b0;

        dir  = DIR_UP;
        mode = CNT_WRAP;
        step = 4'd0;
        adv_chk("step0", 0, 0);
        step = 4'd15;
        adv_chk("bigstep1", 9, 0);
        adv_chk("bigstep2", 8, 1);
        dir  = DIR_DOWN;
        step = 4'd3;
        adv_chk("dwrap1", 5, 0);
        adv_chk("dwrap2", 2, 0);
        adv_chk("dwrap3", 9, 1);
        dir  = DIR_UP;
        mode = CNT_SAT;
        step = 4'd5;
        adv_chk("usat clip", 9, 1);
        load     = 1'b1;
        load_val = 4'd4;
        adv_chk("ld4", 4, 0);
        load = 1'b0;
        adv_chk("usat exact", 9, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
